multi_cycle_control: RTL and testbench

- Main control FSM for the 16-bit multi-cycle processor.
- Drives the ALU-stage datapath select, operation and PC-select lines, plus memory, IR, register-file and PC write strobes, from a registered state.
- Consumes the instruction opcode/funct fields and the ALU Zero/Negative flags fed back from the datapath.
- Sits beside the datapath and is the only source of its sequencing.

---
 rtl/multi_cycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Main sequencing FSM for the 16-bit multi-cycle processor (Moore outputs plus live branch PCWrite).
// Optional macro CTRL_BLT_EN adds opcode 7 (BLT) taking the branch when input_negative is set.
module multi_cycle_control #(
    parameter int MEM_LATENCY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] input_opcode,
    input  logic [3:0] input_funct,
    input  logic       input_Zero,
    input  logic       input_negative,
    output logic [1:0] output_ALUSrcA,
    output logic [1:0] output_ALUSrcB,
    output logic [3:0] output_ALUOp,
    output logic       output_PCSrc,
    output logic       output_PCWrite,
    output logic       output_IRWrite,
    output logic       output_MemRead,
    output logic       output_MemWrite,
    output logic       output_IorD,
    output logic       output_RegWrite,
    output logic       output_MemtoReg,
    output logic       output_halted,
    output logic [3:0] debug_state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_PASS_A = 4'd15;
    localparam logic [2:0] LAT       = 3'(MEM_LATENCY);

    state_t     state, next_state;
    logic [2:0] wait_cnt, wait_cnt_next;
    logic       wait_done;
    logic       branch_taken;

    assign wait_done   = (wait_cnt == LAT);
    assign debug_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= 3'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Condition evaluated against the live ALU flags in the BRANCH cycle.
    always_comb begin
        branch_taken = 1'b0;
        case (input_opcode)
            4'd4:    branch_taken = input_Zero;
            4'd5:    branch_taken = !input_Zero;
`ifdef CTRL_BLT_EN
            4'd7:    branch_taken = input_negative;
`endif
            default: branch_taken = 1'b0;
        endcase
    end

`ifndef CTRL_BLT_EN
    logic unused_negative;
    assign unused_negative = input_negative;
`endif

    always_comb begin
        next_state      = FETCH;
        wait_cnt_next   = 3'd0;
        output_ALUSrcA  = 2'd0;
        output_ALUSrcB  = 2'd0;
        output_ALUOp    = OP_ADD;
        output_PCSrc    = 1'b0;
        output_PCWrite  = 1'b0;
        output_IRWrite  = 1'b0;
        output_MemRead  = 1'b0;
        output_MemWrite = 1'b0;
        output_IorD     = 1'b0;
        output_RegWrite = 1'b0;
        output_MemtoReg = 1'b0;
        output_halted   = 1'b0;
        // Reset cycle keeps every strobe and select at zero.
        if (!reset) begin
            case (state)
                FETCH: begin
                    output_MemRead = 1'b1;
                    output_ALUSrcB = 2'd1;
                    if (wait_done) begin
                        output_IRWrite = 1'b1;
                        output_PCWrite = 1'b1;
                        next_state     = DECODE;
                    end else begin
                        wait_cnt_next = wait_cnt + 3'd1;
                        next_state    = FETCH;
                    end
                end
                DECODE: begin
                    output_ALUSrcB = 2'd2;
                    case (input_opcode)
                        4'd0:       next_state = EXEC_R;
                        4'd1:       next_state = EXEC_I;
                        4'd2, 4'd3: next_state = MEM_ADDR;
                        4'd4, 4'd5: next_state = BRANCH;
`ifdef CTRL_BLT_EN
                        4'd7:       next_state = BRANCH;
`endif
                        4'd6:       next_state = JUMP;
                        4'd15:      next_state = HALT;
                        default:    next_state = FETCH;
                    endcase
                end
                EXEC_R: begin
                    output_ALUSrcA = 2'd2;
                    output_ALUOp   = input_funct;
                    next_state     = ALU_WB;
                end
                EXEC_I: begin
                    output_ALUSrcA = 2'd2;
                    output_ALUSrcB = 2'd2;
                    next_state     = ALU_WB;
                end
                ALU_WB: begin
                    output_RegWrite = 1'b1;
                end
                MEM_ADDR: begin
                    output_ALUSrcA = 2'd2;
                    output_ALUSrcB = 2'd2;
                    case (input_opcode)
                        4'd2:    next_state = MEM_RD;
                        4'd3:    next_state = MEM_WR;
                        default: next_state = FETCH;
                    endcase
                end
                MEM_RD: begin
                    output_MemRead = 1'b1;
                    output_IorD    = 1'b1;
                    if (wait_done) begin
                        next_state = MEM_WB;
                    end else begin
                        wait_cnt_next = wait_cnt + 3'd1;
                        next_state    = MEM_RD;
                    end
                end
                MEM_WB: begin
                    output_RegWrite = 1'b1;
                    output_MemtoReg = 1'b1;
                end
                MEM_WR: begin
                    output_MemWrite = 1'b1;
                    output_IorD     = 1'b1;
                end
                BRANCH: begin
                    output_ALUSrcA = 2'd2;
                    output_ALUOp   = OP_SUB;
                    output_PCSrc   = 1'b1;
                    output_PCWrite = branch_taken;
                end
                JUMP: begin
                    output_ALUSrcA = 2'd3;
                    output_ALUOp   = OP_PASS_A;
                    output_PCWrite = 1'b1;
                end
                HALT: begin
                    output_halted = 1'b1;
                    next_state    = HALT;
                end
                default: next_state = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized bench for multi_cycle_control: per-instruction expected output sequences built from the ISA rules.
module tb_multi_cycle_control;

    localparam int MEM_LAT = 2;
    localparam int W       = 19;  // {branch kind[1:0], output vector[16:0]}

    logic       clk;
    logic       reset;
    logic [3:0] input_opcode;
    logic [3:0] input_funct;
    logic       input_Zero;
    logic       input_negative;
    logic [1:0] output_ALUSrcA;
    logic [1:0] output_ALUSrcB;
    logic [3:0] output_ALUOp;
    logic       output_PCSrc;
    logic       output_PCWrite;
    logic       output_IRWrite;
    logic       output_MemRead;
    logic       output_MemWrite;
    logic       output_IorD;
    logic       output_RegWrite;
    logic       output_MemtoReg;
    logic       output_halted;
    logic [3:0] debug_state;

    logic [W-1:0] exp_q[$];
    int n_cmp;
    int n_err;

    multi_cycle_control #(.MEM_LATENCY(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .input_opcode(input_opcode), .input_funct(input_funct),
        .input_Zero(input_Zero), .input_negative(input_negative),
        .output_ALUSrcA(output_ALUSrcA), .output_ALUSrcB(output_ALUSrcB),
        .output_ALUOp(output_ALUOp), .output_PCSrc(output_PCSrc),
        .output_PCWrite(output_PCWrite), .output_IRWrite(output_IRWrite),
        .output_MemRead(output_MemRead), .output_MemWrite(output_MemWrite),
        .output_IorD(output_IorD), .output_RegWrite(output_RegWrite),
        .output_MemtoReg(output_MemtoReg), .output_halted(output_halted),
        .debug_state(debug_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] dut_vec();
        return {output_halted, output_ALUSrcA, output_ALUSrcB, output_ALUOp, output_PCSrc,
                output_PCWrite, output_IRWrite, output_MemRead, output_MemWrite, output_IorD,
                output_RegWrite, output_MemtoReg};
    endfunction

    // Output vector layout matches dut_vec(); PCWrite is bit 6.
    function automatic logic [16:0] ov(input logic h, input logic [1:0] a, input logic [1:0] b,
                                       input logic [3:0] op, input logic pcs, input logic pcw,
                                       input logic irw, input logic mr, input logic mw,
                                       input logic iord, input logic rw, input logic m2r);
        return {h, a, b, op, pcs, pcw, irw, mr, mw, iord, rw, m2r};
    endfunction

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // Reference model: expected per-cycle outputs of one instruction.
    task automatic build(input logic [3:0] op, input logic [3:0] fn);
        exp_q.delete();
        for (int i = 0; i < MEM_LAT; i++) exp_q.push_back({2'd0, ov(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0)});
        exp_q.push_back({2'd0, ov(0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0)});
        exp_q.push_back({2'd0, ov(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        case (op)
            4'd0: begin
                exp_q.push_back({2'd0, ov(0, 2, 0, fn, 0, 0, 0, 0, 0, 0, 0, 0)});
                exp_q.push_back({2'd0, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
            end
            4'd1: begin
                exp_q.push_back({2'd0, ov(0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
                exp_q.push_back({2'd0, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
            end
            4'd2: begin
                exp_q.push_back({2'd0, ov(0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
                for (int i = 0; i <= MEM_LAT; i++) exp_q.push_back({2'd0, ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0)});
                exp_q.push_back({2'd0, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)});
            end
            4'd3: begin
                exp_q.push_back({2'd0, ov(0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
                exp_q.push_back({2'd0, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0)});
            end
            4'd4: exp_q.push_back({2'd1, ov(0, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)});
            4'd5: exp_q.push_back({2'd2, ov(0, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)});
`ifdef CTRL_BLT_EN
            4'd7: exp_q.push_back({2'd3, ov(0, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)});
`endif
            4'd6: exp_q.push_back({2'd0, ov(0, 3, 0, 15, 0, 1, 0, 0, 0, 0, 0, 0)});
            4'd15: for (int i = 0; i < 12; i++) exp_q.push_back({2'd0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
            default: ;
        endcase
    endtask

    // Driver: entered at a falling edge in the first FETCH cycle; leaves at the next instruction's first cycle.
    // zf/nf force the flags (-1 = random each cycle); abort_at asserts reset at that cycle index.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input int zf, input int nf,
                             input int abort_at);
        logic [W-1:0] entry;
        logic [16:0]  exp;
        bit           done;
        done = 0;
        input_opcode = op;
        input_funct  = fn;
        build(op, fn);
        for (int i = 0; i < exp_q.size() && !done; i++) begin
            entry          = exp_q[i];
            input_Zero     = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
            input_negative = (nf < 0) ? 1'($urandom_range(0, 1)) : 1'(nf);
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check($sformatf("op%0d_reset_c%0d", op, i), dut_vec(), 17'd0);
                @(negedge clk);
                reset = 1'b0;
                done  = 1;
            end else begin
                #1;
                exp = entry[16:0];
                case (entry[18:17])
                    2'd1:    exp[6] = input_Zero;
                    2'd2:    exp[6] = !input_Zero;
                    2'd3:    exp[6] = input_negative;
                    default: ;
                endcase
                check($sformatf("op%0d_c%0d", op, i), dut_vec(), exp);
                @(negedge clk);
            end
        end
    endtask

    task automatic reset_cycle(input string tag);
        reset = 1'b1;
        #1;
        check(tag, dut_vec(), 17'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int op;
        int ab;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        input_opcode = 4'd0;
        input_funct = 4'd0;
        input_Zero = 1'b0;
        input_negative = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_out", dut_vec(), 17'd0);
        @(negedge clk);
        reset = 1'b0;

        run_instr(4'd0, 4'd1, -1, -1, -1);
        run_instr(4'd2, 4'd0, -1, -1, -1);
        run_instr(4'd3, 4'd0, -1, -1, -1);
        run_instr(4'd1, 4'd0, -1, -1, -1);
        run_instr(4'd4, 4'd0, 1, -1, -1);
        run_instr(4'd4, 4'd0, 0, -1, -1);
        run_instr(4'd5, 4'd0, 0, -1, -1);
        run_instr(4'd5, 4'd0, 1, -1, -1);
        run_instr(4'd6, 4'd0, -1, -1, -1);
        run_instr(4'd7, 4'd0, -1, 1, -1);
        run_instr(4'd7, 4'd0, -1, 0, -1);
        run_instr(4'd9, 4'd0, -1, -1, -1);
        run_instr(4'd3, 4'd0, -1, -1, MEM_LAT + 3);
        run_instr(4'd15, 4'd0, -1, -1, -1);
        reset_cycle("halt_reset");
        run_instr(4'd0, 4'd6, -1, -1, -1);

        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 15);
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, MEM_LAT + 5)) : -1;
            run_instr(4'(op), 4'($urandom_range(0, 15)), -1, -1, ab);
            if (op == 15) reset_cycle("rand_halt_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
